// File: rtl/arb2_rr_mux.sv
// arb2_rr_mux: two-input round-robin arbiter feeding a one-entry output buffer.
// Each requester and the output use a val/rdy handshake.
// Optional feature macro: ARB2_RR_MUX_BYPASS_EN. When it is defined and the
// buffer is empty, the granted input passes straight to the output in the
// same cycle.

module arb2_rr_mux #(
    parameter int nbits = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_val,
    output logic             in0_rdy,
    input  logic [nbits-1:0] in0_msg,
    input  logic             in1_val,
    output logic             in1_rdy,
    input  logic [nbits-1:0] in1_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out_msg,
    output logic             out_src
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic             prio;
    logic [nbits-1:0] buf_msg;
    logic             buf_src;

    logic             gnt0;
    logic             gnt1;
    logic             gnt_src;
    logic [nbits-1:0] gnt_msg;
    logic             can_accept;
    logic             xfer_in;
`ifdef ARB2_RR_MUX_BYPASS_EN
    logic             bypass;
`endif

    // Grant selection, input-side ready and output drive; rdy never looks at out_val
    always_comb begin
        gnt0       = in0_val && (!in1_val || !prio);
        gnt1       = in1_val && (!in0_val || prio);
        gnt_src    = gnt1;
        gnt_msg    = gnt1 ? in1_msg : in0_msg;
        can_accept = (state == EMPTY) || out_rdy;
        in0_rdy    = !reset && can_accept && gnt0;
        in1_rdy    = !reset && can_accept && gnt1;
        xfer_in    = in0_rdy || in1_rdy;
`ifdef ARB2_RR_MUX_BYPASS_EN
        bypass     = !reset && (state == EMPTY) && out_rdy && (gnt0 || gnt1);
        out_val    = !reset && ((state == FULL) || bypass);
        out_msg    = bypass ? gnt_msg : buf_msg;
        out_src    = bypass ? gnt_src : buf_src;
`else
        out_val    = !reset && (state == FULL);
        out_msg    = buf_msg;
        out_src    = buf_src;
`endif
    end

    // Buffer occupancy, buffered message/source and round-robin priority update
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            prio    <= 1'b0;
            buf_msg <= '0;
            buf_src <= 1'b0;
        end else begin
            if (xfer_in) begin
                prio <= ~gnt_src;
`ifdef ARB2_RR_MUX_BYPASS_EN
                if (!bypass) begin
                    state   <= FULL;
                    buf_msg <= gnt_msg;
                    buf_src <= gnt_src;
                end
`else
                state   <= FULL;
                buf_msg <= gnt_msg;
                buf_src <= gnt_src;
`endif
            end else if (out_val && out_rdy) begin
                state <= EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_arb2_rr_mux.sv
// Testbench for arb2_rr_mux: directed vectors, expected outputs queued in a
// scoreboard and checked by an independent monitor on the falling edge.

module tb_arb2_rr_mux;

    logic       clk;
    logic       reset;
    logic       in0_val;
    logic       in0_rdy;
    logic [3:0] in0_msg;
    logic       in1_val;
    logic       in1_rdy;
    logic [3:0] in1_msg;
    logic       out_val;
    logic       out_rdy;
    logic [3:0] out_msg;
    logic       out_src;

    int         checks;
    int         failures;
    logic [4:0] exp_q[$];
    logic [4:0] exp_front;

    arb2_rr_mux #(.nbits(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .in0_val (in0_val),
        .in0_rdy (in0_rdy),
        .in0_msg (in0_msg),
        .in1_val (in1_val),
        .in1_rdy (in1_rdy),
        .in1_msg (in1_msg),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_msg (out_msg),
        .out_src (out_src)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v0, input logic [3:0] m0,
                                  input logic v1, input logic [3:0] m1,
                                  input logic ordy);
        in0_val = v0;
        in0_msg = m0;
        in1_val = v1;
        in1_msg = m1;
        out_rdy = ordy;
    endtask

    // Reset with every requester active: nothing may be accepted or shown
    task automatic do_reset();
        reset = 1'b1;
        apply_stimulus(1'b1, 4'hF, 1'b1, 4'hF, 1'b1);
        @(negedge clk);
        check_output("reset_in0_rdy", {7'd0, in0_rdy}, 8'd0);
        check_output("reset_in1_rdy", {7'd0, in1_rdy}, 8'd0);
        check_output("reset_out_val", {7'd0, out_val}, 8'd0);
        tick();
        reset = 1'b0;
        apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        check_output("post_reset_out_val", {7'd0, out_val}, 8'd0);
        check_output("post_reset_out_msg", {4'd0, out_msg}, 8'd0);
        check_output("post_reset_out_src", {7'd0, out_src}, 8'd0);
        tick();
    endtask

    // Monitor: every output transfer must match the oldest queued expectation
    always @(negedge clk) begin
        if (!reset && out_val && out_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output: got src=%0d msg=%0h expected none", out_src, out_msg);
            end else begin
                exp_front = exp_q.pop_front();
                check_output("out_msg", {4'd0, out_msg}, {4'd0, exp_front[3:0]});
                check_output("out_src", {7'd0, out_src}, {7'd0, exp_front[4]});
            end
        end
    end

    // Directed stimulus sequence
    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);

        // Single request from in0, one-cycle latency
        do_reset();
        apply_stimulus(1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
        @(negedge clk);
        check_output("t1_in0_rdy", {7'd0, in0_rdy}, 8'd1);
        check_output("t1_in1_rdy", {7'd0, in1_rdy}, 8'd0);
        exp_q.push_back({1'b0, 4'hA});
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
`ifndef ARB2_RR_MUX_BYPASS_EN
        @(negedge clk);
        check_output("t1_out_val_latency", {7'd0, out_val}, 8'd1);
`endif
        tick();
        tick();

        // Both requesters valid: strict alternation starting with in0
        do_reset();
        apply_stimulus(1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output("t2_in0_rdy", {7'd0, in0_rdy}, (k % 2 == 0) ? 8'd1 : 8'd0);
            check_output("t2_in1_rdy", {7'd0, in1_rdy}, (k % 2 == 1) ? 8'd1 : 8'd0);
            exp_q.push_back((k % 2 == 0) ? {1'b0, 4'h3} : {1'b1, 4'hC});
            tick();
        end
        apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        tick();

        // Backpressure holds the buffer, then dequeue and enqueue together
        do_reset();
        apply_stimulus(1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
        @(negedge clk);
        check_output("t3_in0_rdy", {7'd0, in0_rdy}, 8'd1);
        exp_q.push_back({1'b0, 4'h5});
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b1, 4'hE, 1'b0);
`ifndef ARB2_RR_MUX_BYPASS_EN
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output("t3_hold_out_val", {7'd0, out_val}, 8'd1);
            check_output("t3_hold_out_msg", {4'd0, out_msg}, 8'h05);
            check_output("t3_hold_in0_rdy", {7'd0, in0_rdy}, 8'd0);
            check_output("t3_hold_in1_rdy", {7'd0, in1_rdy}, 8'd0);
            tick();
        end
        out_rdy = 1'b1;
        @(negedge clk);
        check_output("t3_in1_rdy", {7'd0, in1_rdy}, 8'd1);
        exp_q.push_back({1'b1, 4'hE});
        tick();
`endif
        apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        tick();

        // Lone in1 accepted back-to-back, then in0 wins the tie
        do_reset();
        apply_stimulus(1'b0, 4'h0, 1'b1, 4'h1, 1'b1);
        @(negedge clk);
        check_output("t4_first_in1_rdy", {7'd0, in1_rdy}, 8'd1);
        exp_q.push_back({1'b1, 4'h1});
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b1, 4'h2, 1'b1);
        @(negedge clk);
        check_output("t4_second_in1_rdy", {7'd0, in1_rdy}, 8'd1);
        exp_q.push_back({1'b1, 4'h2});
        tick();
        apply_stimulus(1'b1, 4'h6, 1'b1, 4'h7, 1'b1);
        @(negedge clk);
        check_output("t4_tie_in0_rdy", {7'd0, in0_rdy}, 8'd1);
        check_output("t4_tie_in1_rdy", {7'd0, in1_rdy}, 8'd0);
        exp_q.push_back({1'b0, 4'h6});
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        tick();

        // Reset while holding 4'h9: message dropped, priority back to in0
        do_reset();
        apply_stimulus(1'b1, 4'h9, 1'b0, 4'h0, 1'b0);
        @(negedge clk);
        check_output("t5_in0_rdy", {7'd0, in0_rdy}, 8'd1);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_output("t5_reset_out_val", {7'd0, out_val}, 8'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_output("t5_after_out_val", {7'd0, out_val}, 8'd0);
        tick();
        apply_stimulus(1'b1, 4'hB, 1'b1, 4'hD, 1'b1);
        @(negedge clk);
        check_output("t5_prio_in0_rdy", {7'd0, in0_rdy}, 8'd1);
        check_output("t5_prio_in1_rdy", {7'd0, in1_rdy}, 8'd0);
        exp_q.push_back({1'b0, 4'hB});
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        tick();

`ifdef ARB2_RR_MUX_BYPASS_EN
        // Zero-latency pass-through when the buffer is empty
        do_reset();
        apply_stimulus(1'b1, 4'h7, 1'b0, 4'h0, 1'b1);
        exp_q.push_back({1'b0, 4'h7});
        @(negedge clk);
        check_output("t6_bypass_out_val", {7'd0, out_val}, 8'd1);
        check_output("t6_bypass_out_msg", {4'd0, out_msg}, 8'h07);
        check_output("t6_bypass_out_src", {7'd0, out_src}, 8'd0);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        @(negedge clk);
        check_output("t6_buffer_empty", {7'd0, out_val}, 8'd0);
        tick();
`endif

        tick();
        check_output("scoreboard_drained", exp_q.size() > 255 ? 8'hFF : 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/arb2_rr_mux.md
ARB2_RR_MUX -- requirements
Module: arb2_rr_mux

Interface
REQ-001 SHALL have parameter: nbits, 4, message width of each requester and of the output.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
REQ-004 SHALL have ports: in0_val  input  1; in0_rdy  output  1; in0_msg  input  nbits; requester 0 val/rdy channel.
REQ-005 SHALL have ports: in1_val  input  1; in1_rdy  output  1; in1_msg  input  nbits; requester 1 val/rdy channel.
REQ-006 SHALL have ports: out_val  output  1; out_rdy  input  1; out_msg  output  nbits; shared output channel.
REQ-007 SHALL have port: out_src  output  1  index of the requester whose message is on out_msg.

Function
REQ-008 SHALL treat a transfer on any channel as val && rdy high in the same cycle.
REQ-009 SHALL hold a one-entry output buffer (state EMPTY/FULL), a priority bit prio, and buffered msg/src registers.
REQ-010 SHALL drive out_val = FULL, out_msg = buffered msg, out_src = buffered src.
REQ-011 SHALL compute can_accept = EMPTY || out_rdy (enqueue allowed in the same cycle as dequeue).
REQ-012 SHALL grant: both valid -> requester prio; only one valid -> that requester; none -> no grant.
REQ-013 SHALL assert inX_rdy only when can_accept and requester X is granted; never both rdy in one cycle.
REQ-014 SHALL (inX_rdy may depend on in0_val/in1_val; the output-side rdy SHALL NOT depend on out_val.)
REQ-015 SHALL on input transfer from X load msg/src = inX_msg/X and be FULL next cycle (latency 1 cycle).
REQ-016 SHALL on output transfer with no input transfer go EMPTY next cycle; both transfers -> stay FULL with new data.
REQ-017 SHALL set prio to the non-granted requester after each input transfer; prio unchanged when no transfer.
REQ-018 SHALL hold out_msg/out_src stable while out_val && !out_rdy.
REQ-019 SHALL sustain one message per cycle when out_rdy held high, alternating requesters if both keep val high.

Reset
REQ-020 SHALL on reset: state EMPTY, prio = 0, buffered msg = 0, src = 0; out_val = 0, in0_rdy = in1_rdy = 0 during reset cycle.
REQ-021 SHALL discard a buffered message on reset mid-operation; no transfer is accepted in the reset cycle.

Configuration
REQ-022 SHALL support macro ARB2_RR_MUX_BYPASS_EN.
REQ-023 SHALL without the macro behave exactly as REQ-008..REQ-021 (registered output, 1-cycle latency).
REQ-024 SHALL with the macro, when EMPTY and out_rdy high and a grant exists: out_val = 1, out_msg/out_src driven combinationally from the granted input, buffer stays EMPTY, prio updates per REQ-017 (0-cycle latency); all other cases as without the macro.

Verification
REQ-025 SHALL cover: reset, in0_val=1 msg 4'hA, in1_val=0, out_rdy=1 -> in0_rdy=1; next cycle out_val=1, out_msg=4'hA, out_src=0.
REQ-026 SHALL cover: both val, msgs 4'h3/4'hC, out_rdy=1 for 4 cycles -> outputs 3(src0), C(src1), 3(src0), C(src1) in consecutive cycles.
REQ-027 SHALL cover: FULL with 4'h5, out_rdy=0 for 3 cycles, in1_val=1 -> out_msg holds 4'h5, in0_rdy=in1_rdy=0; on out_rdy=1 dequeue and enqueue same cycle.
REQ-028 SHALL cover: only in1 valid repeatedly (4'h1,4'h2) -> both accepted back-to-back despite prio; then both valid -> in0 granted first.
REQ-029 SHALL cover: reset asserted while FULL with 4'h9 -> out_val=0 next cycle, 4'h9 never delivered, prio=0.
REQ-030 SHALL cover (with ARB2_RR_MUX_BYPASS_EN): EMPTY, out_rdy=1, in0_val=1 msg 4'h7 -> same-cycle out_val=1, out_msg=4'h7, out_src=0.
